uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two requesters: the command-echo path, fed by the command decoder's Cmd/NewCmd stream and gated by its echo-on state, and the captured-sample data stream.
- Sequences the transmitter's start/busy handshake one byte at a time.
- Gives the data stream bounded bursts, so echo bytes are never starved and data bytes are never interleaved mid-burst.

---
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between command echo and a bursty data stream; ECHO_CRLF_EN appends 0x0A after an echoed 0x0D
module uart_tx_arbiter #(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       echo_en,
  input  logic [7:0] cmd,
  input  logic       new_cmd,
  input  logic [7:0] data_byte,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       grant_data,
  output logic       echo_drop
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_ACK  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       echo_q, echo_d;
  logic             echo_full_q, echo_full_d;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_nxt;
  logic             can_sel, sel_data, sel_echo, load, burst_end;
`ifdef ECHO_CRLF_EN
  logic             crlf_q, crlf_d;
`endif
  // A start is only issued from IDLE once the transmitter is quiet; a locked burst with data pending beats a waiting echo
  assign can_sel    = (state_q == IDLE) && !tx_busy;
  assign sel_data   = can_sel && data_valid && (lock_q || !echo_full_q);
  assign sel_echo   = can_sel && echo_full_q && !(lock_q && data_valid);
  assign load       = new_cmd && echo_en;
  assign cnt_nxt    = lock_q ? cnt_q + CNT_W'(1) : CNT_W'(1);
  assign burst_end  = cnt_nxt == CNT_W'(BURST_LEN);
  assign data_ready = sel_data && rst_n;
  assign echo_drop  = load && echo_full_q && !sel_echo;
  assign tx_start   = state_q == START;
  assign tx_data    = tx_data_q;
  assign grant_data = lock_q;
  // Echo holding register: a byte arriving while the previous one is consumed replaces it, otherwise a full register drops it
  always_comb begin
    echo_d      = echo_q;
    echo_full_d = sel_echo ? 1'b0 : echo_full_q;
    if (load && (!echo_full_q || sel_echo)) begin
      echo_d      = cmd;
      echo_full_d = 1'b1;
    end
  end
  // Byte sequencer and burst accounting
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
`ifdef ECHO_CRLF_EN
    crlf_d    = crlf_q;
`endif
    if (state_q == IDLE) begin
      if (sel_data) begin
        state_d   = START;
        tx_data_d = data_byte;
        lock_d    = !burst_end;
        cnt_d     = burst_end ? '0 : cnt_nxt;
      end else if (sel_echo) begin
        state_d   = START;
        tx_data_d = echo_q;
`ifdef ECHO_CRLF_EN
        crlf_d    = echo_q == 8'h0D;
`endif
      end
      if (lock_q && !data_valid) begin
        lock_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (state_q == START) begin
      state_d = WAIT_ACK;
    end else if (state_q == WAIT_ACK) begin
      state_d = tx_busy ? WAIT_DONE : WAIT_ACK;
    end else if (!tx_busy) begin
`ifdef ECHO_CRLF_EN
      state_d   = crlf_q ? START : IDLE;
      tx_data_d = crlf_q ? 8'h0A : tx_data_q;
      crlf_d    = 1'b0;
`else
      state_d   = IDLE;
`endif
    end
  end
  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      echo_q      <= '0;
      echo_full_q <= 1'b0;
      lock_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      echo_q      <= echo_d;
      echo_full_q <= echo_full_d;
      lock_q      <= lock_d;
      cnt_q       <= cnt_d;
    end
  end
`ifdef ECHO_CRLF_EN
  // Pending line-feed after an echoed carriage return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crlf_q <= 1'b0;
    else        crlf_q <= crlf_d;
  end
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a busy-for-10-cycles transmitter model
module tb_uart_tx_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0, echo_en = 1'b0, new_cmd = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       data_valid, data_ready, tx_busy, tx_start, grant_data, echo_drop;
  logic [7:0] data_byte, tx_data;
  int         n_chk = 0, n_fail = 0, drops = 0, busy_cnt = 0, t0 = 0, d0 = 0;
  logic [7:0] txq[$];
  logic       gq[$];
  logic [7:0] dq[$];
  logic       take;

  typedef struct {
    logic       en;
    logic       nc;
    logic [7:0] c;
    logic       dv;
    logic [7:0] d;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    int         dr;
  } vec_t;
  vec_t tbl[6];
  logic [7:0] fair_b[6];
  logic       fair_g[6];

  uart_tx_arbiter #(.BURST_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .echo_en(echo_en), .cmd(cmd), .new_cmd(new_cmd),
    .data_byte(data_byte), .data_valid(data_valid), .data_ready(data_ready),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .grant_data(grant_data), .echo_drop(echo_drop)
  );

  always #5 clk = ~clk;

  assign tx_busy = busy_cnt != 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;

  always @(negedge clk)
    if (rst_n) begin
      if (tx_start) begin
        txq.push_back(tx_data);
        gq.push_back(grant_data);
      end
      if (echo_drop) drops++;
    end

  initial begin
    data_valid = 1'b0;
    data_byte  = 8'h00;
    forever begin
      @(negedge clk);
      take = data_valid && data_ready;
      @(posedge clk);
      #1;
      if (take && dq.size() != 0) void'(dq.pop_front());
      data_valid = dq.size() != 0;
      data_byte  = data_valid ? dq[0] : 8'h00;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    new_cmd = 1'b0;
    dq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t0 = txq.size();
    d0 = drops;
  endtask

  task automatic strobe(input logic [7:0] c);
    @(posedge clk);
    #1;
    cmd     = c;
    new_cmd = 1'b1;
    @(posedge clk);
    #1;
    new_cmd = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int b = budget;
    while (txq.size() - t0 < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (txq.size() - t0 < n) chk("timeout", txq.size() - t0, n);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 8'h45, 1'b0, 8'h00, 1, 8'h45, 8'h00, 0};
    tbl[1] = '{1'b0, 1'b1, 8'h65, 1'b0, 8'h00, 0, 8'h00, 8'h00, 0};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 1, 8'h5A, 8'h00, 0};
    tbl[3] = '{1'b1, 1'b1, 8'h45, 1'b1, 8'h33, 2, 8'h45, 8'h33, 0};
    tbl[4] = '{1'b0, 1'b1, 8'h99, 1'b1, 8'h77, 1, 8'h77, 8'h00, 0};
    tbl[5] = '{1'b1, 1'b0, 8'h12, 1'b0, 8'h00, 0, 8'h00, 8'h00, 0};
    fair_b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h45, 8'h04};
    fair_g = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {tx_start, tx_data, data_ready, grant_data, echo_drop}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      echo_en = tbl[i].en;
      if (tbl[i].nc) strobe(tbl[i].c);
      else begin
        @(posedge clk);
        #1;
      end
      if (tbl[i].dv) dq.push_back(tbl[i].d);
      repeat (50) @(negedge clk);
      chk($sformatf("vec%0d_count", i), txq.size() - t0, tbl[i].n);
      if (tbl[i].n >= 1) chk($sformatf("vec%0d_byte0", i), txq[t0], tbl[i].b0);
      if (tbl[i].n >= 2) chk($sformatf("vec%0d_byte1", i), txq[t0 + 1], tbl[i].b1);
      chk($sformatf("vec%0d_drops", i), drops - d0, tbl[i].dr);
    end

    do_reset();
    echo_en = 1'b1;
    for (int i = 0; i < 6; i++) dq.push_back(8'(i));
    wait_tx(2, 60);
    strobe(8'h45);
    wait_tx(6, 120);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fair_byte%0d", i), txq[t0 + i], fair_b[i]);
      chk($sformatf("fair_grant%0d", i), gq[t0 + i], fair_g[i]);
    end

    do_reset();
    echo_en = 1'b1;
    dq.push_back(8'hD0);
    wait_tx(1, 40);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    cmd     = 8'h41;
    new_cmd = 1'b1;
    @(posedge clk);
    #1;
    cmd = 8'h42;
    @(posedge clk);
    #1;
    new_cmd = 1'b0;
    wait_tx(2, 60);
    repeat (30) @(negedge clk);
    chk("drop_count_tx", txq.size() - t0, 2);
    chk("drop_echo_byte", txq[t0 + 1], 8'h41);
    chk("drop_pulses", drops - d0, 1);

    do_reset();
    dq.push_back(8'h20);
    dq.push_back(8'h21);
    wait_tx(2, 60);
    repeat (20) @(negedge clk);
    chk("early_grant_off", grant_data, 1'b0);
    for (int i = 0; i < 4; i++) dq.push_back(8'h30 + 8'(i));
    wait_tx(6, 120);
    chk("early_grant0", gq[t0 + 2], 1'b1);
    chk("early_grant1", gq[t0 + 3], 1'b1);
    chk("early_grant2", gq[t0 + 4], 1'b1);
    chk("early_grant3", gq[t0 + 5], 1'b0);

    do_reset();
    dq.push_back(8'hA5);
    dq.push_back(8'hA6);
    wait_tx(1, 40);
    repeat (4) @(negedge clk);
    chk("pre_reset_grant", grant_data, 1'b1);
    rst_n = 1'b0;
    dq.delete();
    @(negedge clk);
    chk("mid_reset_outputs", {tx_start, tx_data, data_ready, grant_data, echo_drop}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t0 = txq.size();
    dq.push_back(8'h5C);
    wait_tx(1, 40);
    chk("post_reset_byte", txq[t0], 8'h5C);

    do_reset();
    echo_en = 1'b1;
    strobe(8'h0D);
    dq.push_back(8'h11);
    dq.push_back(8'h12);
    wait_tx(3, 100);
    chk("cr_byte0", txq[t0], 8'h0D);
`ifdef ECHO_CRLF_EN
    chk("cr_byte1", txq[t0 + 1], 8'h0A);
    chk("cr_byte2", txq[t0 + 2], 8'h11);
`else
    chk("cr_byte1", txq[t0 + 1], 8'h11);
    chk("cr_byte2", txq[t0 + 2], 8'h12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
